// File: rtl/fifo_pkg.sv
// Shared types and helpers for the 1R1W flag FIFO.
package fifo_pkg;

   function automatic int width_of(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   typedef struct packed {
      logic push;
      logic pop;
   } fifo_op_t;

endpackage

// File: rtl/fifo_ram_1r1w.sv
// Storage array: synchronous write, combinational read, no reset.
module fifo_ram_1r1w
   import fifo_pkg::*;
#(
   parameter int DataWidth = 8,
   parameter int Entries = 16,
   localparam int AddrWidth = width_of(Entries)
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [AddrWidth-1:0] waddr,
   input  logic [DataWidth-1:0] wdata,
   input  logic [AddrWidth-1:0] raddr,
   output logic [DataWidth-1:0] rdata
);

   logic [DataWidth-1:0] mem [Entries];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_1r1w_flags.sv
// Single-clock FIFO, any depth >= 2, optional output flop, level flags,
// synchronous flush and sticky overflow.
module fifo_1r1w_flags
   import fifo_pkg::*;
#(
   parameter int DataWidth = 8,
   parameter int Depth = 16,
   parameter int OutputReg = 0,
   parameter int AlmostFullThresh = Depth - 2,
   parameter int AlmostEmptyThresh = 1,
   localparam int CountWidth = $clog2(Depth + 1)
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  flush_i,
   input  logic [DataWidth-1:0]  data_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic                  valid_o,
   output logic [DataWidth-1:0]  data_o,
   input  logic                  ready_i,
   output logic [CountWidth-1:0] count_o,
   output logic                  almost_full_o,
   output logic                  almost_empty_o,
   output logic                  overflow_o
);

   localparam int Entries = (OutputReg != 0) ? Depth - 1 : Depth;
   localparam int PtrWidth = width_of(Entries);

   logic [CountWidth-1:0] count;
   logic [PtrWidth-1:0]   wr_ptr;
   logic [PtrWidth-1:0]   rd_ptr;
   logic                  overflow;
   logic [DataWidth-1:0]  rd_data;
   logic                  ram_we;
   logic                  ram_re;
   fifo_op_t              op;

   function automatic logic [PtrWidth-1:0] ptr_inc(
      input logic [PtrWidth-1:0] p
   );
      return (p == PtrWidth'(Entries - 1)) ? '0 : p + PtrWidth'(1);
   endfunction

   assign ready_o = !reset_i && (count != CountWidth'(Depth));
   assign valid_o = (count != '0);
   assign op.push = valid_i && ready_o;
   assign op.pop = valid_o && ready_i;

   assign count_o = count;
   assign overflow_o = overflow;
   assign almost_full_o = (count >= CountWidth'(AlmostFullThresh));
   assign almost_empty_o = (count <= CountWidth'(AlmostEmptyThresh));

   fifo_ram_1r1w #(
      .DataWidth(DataWidth),
      .Entries  (Entries)
   ) u_ram (
      .clk  (clk_i),
      .we   (ram_we && !flush_i),
      .waddr(wr_ptr),
      .wdata(data_i),
      .raddr(rd_ptr),
      .rdata(rd_data)
   );

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         count <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         overflow <= 1'b0;
      end else if (flush_i) begin
         count <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         overflow <= 1'b0;
      end else begin
         if (valid_i && !ready_o) overflow <= 1'b1;
         if (ram_we) wr_ptr <= ptr_inc(wr_ptr);
         if (ram_re) rd_ptr <= ptr_inc(rd_ptr);
         unique case ({op.push, op.pop})
            2'b10: count <= count + CountWidth'(1);
            2'b01: count <= count - CountWidth'(1);
            default: count <= count;
         endcase
      end
   end

   if (OutputReg != 0) begin : g_oreg
      logic                  out_valid;
      logic [DataWidth-1:0]  out_data;
      logic [CountWidth-1:0] stored;
      logic                  bypass;

      // The flop holds the head; storage holds everything behind it.
      assign stored = count - CountWidth'(out_valid);
      assign bypass = !out_valid || (op.pop && stored == '0);
      assign ram_we = op.push && !bypass;
      assign ram_re = op.pop && stored != '0;
      assign data_o = out_data;

      always_ff @(posedge clk_i or posedge reset_i) begin
         if (reset_i) begin
            out_valid <= 1'b0;
            out_data <= '0;
         end else if (flush_i) begin
            out_valid <= 1'b0;
         end else if (op.push && bypass) begin
            out_valid <= 1'b1;
            out_data <= data_i;
         end else if (op.pop) begin
            if (stored != '0) out_data <= rd_data;
            else out_valid <= 1'b0;
         end
      end
   end else begin : g_comb
      assign ram_we = op.push;
      assign ram_re = op.pop;
      assign data_o = rd_data;
   end

endmodule

// File: doc/fifo_1r1w_flags.md
# fifo_1r1w_flags

Parametrised single-clock first-in-first-out queue (FIFO) with a valid/ready handshake on both sides. It generalises the team's power-of-two FIFO in four ways: any depth of at least 2, an optional registered output stage, programmable almost-full/almost-empty flags, and a synchronous flush with a sticky overflow indicator. It sits between producer and consumer pipeline stages that need back-pressure plus early-warning flow control.

## Interface
- `DataWidth`, default 8: payload width in bits, at least 1.
- `Depth`, default 16: total capacity in entries, at least 2; need not be a power of two.
- `OutputReg`, default 0:
  - 0: `data_o` is read combinationally from storage.
  - 1: `data_o` is driven by a flop.
- `AlmostFullThresh`, default Depth-2: `almost_full_o` asserts when `count_o >= AlmostFullThresh`. Legal range 1..Depth.
- `AlmostEmptyThresh`, default 1: `almost_empty_o` asserts when `count_o <= AlmostEmptyThresh`. Legal range 0..Depth-1.
- `CountWidth`, localparam: $clog2(Depth+1).

Ports (clock and reset first):
- `clk_i`  in  1  clock.
- `reset_i`  in  1  reset, asynchronous and active-high.
- `flush_i`  in  1  synchronous clear of all contents.
- `data_i`  in  DataWidth  write payload.
- `valid_i`  in  1  producer offers `data_i`.
- `ready_o`  out  1  FIFO can accept a word.
- `valid_o`  out  1  `data_o` holds the head entry.
- `data_o`  out  DataWidth  head entry.
- `ready_i`  in  1  consumer accepts the head.
- `count_o`  out  CountWidth  current occupancy.
- `almost_full_o`  out  1  occupancy at or above `AlmostFullThresh`.
- `almost_empty_o`  out  1  occupancy at or below `AlmostEmptyThresh`.
- `overflow_o`  out  1  sticky: a word was offered while the FIFO was full.

## Operation
- Push = `valid_i & ready_o`. Pop = `valid_o & ready_i`.
- `ready_o = (count_o != Depth)`. `valid_o = (count_o != 0)`.
- `ready_o` has no combinational path from `ready_i`. When the FIFO is full, a push is refused even in a cycle that also pops.
- Occupancy update:
  - push only: `count_o` + 1.
  - pop only: `count_o` - 1.
  - push and pop together: unchanged.
- Pointers run 0..P-1 and wrap explicitly from P-1 to 0; there is no reliance on power-of-two overflow.
  - OutputReg=0: P = Depth.
  - OutputReg=1: P = Depth-1.
- OutputReg=1 behaviour:
  - The output flop counts toward occupancy.
  - A push into an empty FIFO, or one made while the flop is being vacated with storage empty, loads the flop directly (bypass).
  - Otherwise pushes go to storage, and the flop refills from storage on a pop.
- Order is strict FIFO in both modes; no entry is ever duplicated or dropped.
- `flush_i` takes priority over everything. On the next edge: pointers, count and output-flop valid all go to 0. A push or pop in the flush cycle is ignored; `overflow_o` clears.
- `overflow_o` sets on any cycle with `valid_i & !ready_o` (flush not asserted). It holds until flush or reset.
- `almost_full_o` and `almost_empty_o` are combinational decodes of the registered count.
- `data_o` is don't-care whenever `valid_o` = 0.

## Timing
- Reset (asynchronous assert): count = 0, pointers = 0, `overflow_o` = 0, output-flop valid = 0.
- Output values while `reset_i` is high:
  - `valid_o` = 0, `ready_o` = 0 (forced low during reset), `count_o` = 0.
  - `almost_empty_o` = 1, `almost_full_o` = 0.
  - `data_o` = 0 when OutputReg=1.
- After reset deasserts: `ready_o` = 1 on the first cycle.
- Write-to-read latency is 1 cycle in both modes. A word pushed at edge N is visible with `valid_o` = 1 after edge N, and can be popped at edge N+1.
- Full-throughput push+pop every cycle is sustained in both modes. There are no bubbles at pointer wrap.
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.

## Structure
- `fifo_pkg`: a `clog2`-based width helper and the shared `push`/`pop` enable typedef (`fifo_op_t`).
- Sub-module `fifo_ram_1r1w`:
  - Storage array with a synchronous write port and a combinational read port.
  - Parameters: DataWidth and Entries.
  - It has no reset.
- Top-level responsibilities: pointers, count, flags, output stage.

## Test plan
- Reset then idle, Depth=16:
  - While reset is high: `ready_o` = 0, `valid_o` = 0, `count_o` = 0, `almost_empty_o` = 1.
  - One cycle after release: `ready_o` = 1.
- Fill to full, Depth=5 (non-power-of-two), push 0x01..0x05 with `ready_i` = 0:
  - After the 5th push: `count_o` = 5, `ready_o` = 0, `almost_full_o` = 1 (threshold 3).
  - A 6th offer of 0x06 sets `overflow_o` = 1, and 0x06 is never output.
- Wrap-around ordering, Depth=5, both OutputReg values: 40 streamed words 0x00..0x27 with random `ready_i` stalls -> output is exactly 0x00..0x27 in order.
- Simultaneous push and pop:
  - At count 5 (full): `ready_o` stays 0 and count goes 5 -> 4.
  - At count 2: count stays 2.
  - At count 0: only the push takes effect.
- Flush: with count 3 and `overflow_o` = 1, assert `flush_i` together with push 0xAA -> next cycle `count_o` = 0, `valid_o` = 0, `overflow_o` = 0, and 0xAA is discarded.
- Asynchronous reset mid-stream: assert `reset_i` between clock edges with count 4 -> `valid_o` and `count_o` drop to 0 before the next edge.
